// File: rtl/trivium_pkg.sv
// Shared constants, tap positions, FSM type and load-state helper for the Trivium keystream generator.
package trivium_pkg;

  localparam int STATE_W         = 288;
  localparam int KEY_W           = 80;
  localparam int IV_W            = 80;
  localparam int DEF_INIT_ROUNDS = 1152;

  // Tap positions use eStream numbering (s1..s288); subtract one for a vector index.
  localparam int TAP_T1_A   = 66;
  localparam int TAP_T1_B   = 93;
  localparam int TAP_T2_A   = 162;
  localparam int TAP_T2_B   = 177;
  localparam int TAP_T3_A   = 243;
  localparam int TAP_T3_B   = 288;
  localparam int TAP_T1_AND_A = 91;
  localparam int TAP_T1_AND_B = 92;
  localparam int TAP_T1_FB    = 171;
  localparam int TAP_T2_AND_A = 175;
  localparam int TAP_T2_AND_B = 176;
  localparam int TAP_T2_FB    = 264;
  localparam int TAP_T3_AND_A = 286;
  localparam int TAP_T3_AND_B = 287;
  localparam int TAP_T3_FB    = 69;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } fsm_t;

  // Initial register image: key in s1..s80, iv in s94..s173, s286..s288 set, rest clear.
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] s;
    s                  = '0;
    s[KEY_W-1:0]       = key;
    s[93 +: IV_W]      = iv;
    s[STATE_W-1 -: 3]  = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_stream_if.sv
// Load/key/IV inputs and keystream valid/ready bundle for trivium_stream.
// With TRIVIUM_CNT_EN defined the bundle also carries the 64-bit ks_count.
interface trivium_stream_if #(
  parameter int W = 8
);
  import trivium_pkg::*;

  logic             load;
  logic [KEY_W-1:0] key;
  logic [IV_W-1:0]  iv;
  logic             busy;
  logic             ks_valid;
  logic             ks_ready;
  logic [W-1:0]     ks_data;
`ifdef TRIVIUM_CNT_EN
  logic [63:0]      ks_count;

  modport master (
    input  load, key, iv, ks_ready,
    output busy, ks_valid, ks_data, ks_count
  );
  modport slave (
    output load, key, iv, ks_ready,
    input  busy, ks_valid, ks_data, ks_count
  );
`else
  modport master (
    input  load, key, iv, ks_ready,
    output busy, ks_valid, ks_data
  );
  modport slave (
    output load, key, iv, ks_ready,
    input  busy, ks_valid, ks_data
  );
`endif

endinterface

// File: rtl/trivium_round.sv
// One combinational Trivium step: next state and the keystream bit z of the current state.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s_in,
  output logic [STATE_W-1:0] s_out,
  output logic               z
);

  logic t1;
  logic t2;
  logic t3;
  logic t1_fb;
  logic t2_fb;
  logic t3_fb;

  assign t1 = s_in[TAP_T1_A-1] ^ s_in[TAP_T1_B-1];
  assign t2 = s_in[TAP_T2_A-1] ^ s_in[TAP_T2_B-1];
  assign t3 = s_in[TAP_T3_A-1] ^ s_in[TAP_T3_B-1];

  assign z = t1 ^ t2 ^ t3;

  assign t1_fb = t1 ^ (s_in[TAP_T1_AND_A-1] & s_in[TAP_T1_AND_B-1]) ^ s_in[TAP_T1_FB-1];
  assign t2_fb = t2 ^ (s_in[TAP_T2_AND_A-1] & s_in[TAP_T2_AND_B-1]) ^ s_in[TAP_T2_FB-1];
  assign t3_fb = t3 ^ (s_in[TAP_T3_AND_A-1] & s_in[TAP_T3_AND_B-1]) ^ s_in[TAP_T3_FB-1];

  // Three shift registers s1..93, s94..177, s178..288, each fed at its low end.
  assign s_out = {s_in[286:177], t2_fb, s_in[175:93], t1_fb, s_in[91:0], t3_fb};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator: W unrolled steps per cycle, cycle-counted warm-up, valid/ready output.
// Define TRIVIUM_CNT_EN to add the saturating ks_count of delivered keystream bits.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = DEF_INIT_ROUNDS
) (
  input logic              clk,
  input logic              rst,
  trivium_stream_if.master bus
);

  localparam int               CNT_W    = $clog2(INIT_ROUNDS + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_ROUNDS - W);

  fsm_t               fsm_reg;
  logic [STATE_W-1:0] state_reg;
  logic [CNT_W-1:0]   round_cnt_reg;
  logic               busy_reg;
  logic               ks_valid_reg;
  logic [STATE_W-1:0] state_adv;
  logic [W-1:0]       z_word;
  logic               advance;

  for (genvar gi = 0; gi < W; gi++) begin : g_step
    logic [STATE_W-1:0] s_prev;
    logic [STATE_W-1:0] s_next;
    if (gi == 0) begin : g_first
      assign s_prev = state_reg;
    end else begin : g_chain
      assign s_prev = g_step[gi-1].s_next;
    end
    trivium_round u_round (
      .s_in  (s_prev),
      .s_out (s_next),
      .z     (z_word[gi])
    );
  end

  assign state_adv = g_step[W-1].s_next;
  assign advance   = ks_valid_reg & bus.ks_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      ks_valid_reg  <= 1'b0;
    end else if (bus.load) begin
      // A load always restarts warm-up, dropping any word not yet accepted.
      fsm_reg       <= INIT;
      state_reg     <= load_state(bus.key, bus.iv);
      round_cnt_reg <= '0;
      busy_reg      <= 1'b1;
      ks_valid_reg  <= 1'b0;
    end else begin
      case (fsm_reg)
        INIT: begin
          state_reg     <= state_adv;
          round_cnt_reg <= round_cnt_reg + CNT_STEP;
          if (round_cnt_reg == CNT_LAST) begin
            fsm_reg      <= RUN;
            busy_reg     <= 1'b0;
            ks_valid_reg <= 1'b1;
          end
        end
        RUN: begin
          if (advance) begin
            state_reg <= state_adv;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.ks_valid = ks_valid_reg;
  assign bus.ks_data  = (fsm_reg == RUN) ? z_word : '0;

`ifdef TRIVIUM_CNT_EN
  localparam logic [63:0] COUNT_STEP = 64'(W);
  localparam logic [63:0] COUNT_MAX  = '1;

  logic [63:0] ks_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_count_reg <= '0;
    end else if (bus.load) begin
      ks_count_reg <= '0;
    end else if (advance) begin
      ks_count_reg <= (ks_count_reg > COUNT_MAX - COUNT_STEP) ? COUNT_MAX
                                                              : ks_count_reg + COUNT_STEP;
    end
  end

  assign bus.ks_count = ks_count_reg;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Scoreboard bench for trivium_stream (W=8 and W=64 instances) against a bit-serial Trivium model.
module tb_trivium_stream;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  trivium_stream_if #(.W(8))  bus8 ();
  trivium_stream_if #(.W(64)) bus64 ();

  trivium_stream #(.W(8), .INIT_ROUNDS(1152)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  trivium_stream #(.W(64), .INIT_ROUNDS(1152)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp8_q[$];
  logic [63:0] exp64_q[$];
  logic [63:0] cnt8_exp = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pop8();
    if (exp8_q.size() == 0) return 'x;
    return exp8_q.pop_front();
  endfunction

  function automatic logic [63:0] pop64();
    if (exp64_q.size() == 0) return 'x;
    return exp64_q.pop_front();
  endfunction

  // Bit-serial reference: warm up 1152 steps, then pack 1024 bits as 8-bit words
  // and 4096 bits as 64-bit words, earliest bit in bit 0.
  task automatic gold_fill(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    logic         t1, t2, t3, z;
    logic [7:0]   acc8;
    logic [63:0]  acc64;
    int           b;
    s     = '0;
    acc8  = '0;
    acc64 = '0;
    for (int i = 0; i < 80; i++) begin
      s[i+1]  = k[i];
      s[94+i] = v[i];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    exp8_q.delete();
    exp64_q.delete();
    for (int n = 0; n < 1152 + 4096; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int j = 288; j > 1; j--) s[j] = s[j-1];
      s[1]   = t3;
      s[94]  = t1;
      s[178] = t2;
      if (n >= 1152) begin
        b            = n - 1152;
        acc8[b % 8]   = z;
        acc64[b % 64] = z;
        if ((b % 8) == 7 && b < 1024) exp8_q.push_back({56'h0, acc8});
        if ((b % 64) == 63) exp64_q.push_back(acc64);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic load8(input logic [79:0] k, input logic [79:0] v);
    gold_fill(k, v);
    bus8.key  = k;
    bus8.iv   = v;
    bus8.load = 1'b1;
    @(negedge clk);
    bus8.load = 1'b0;
    cnt8_exp  = '0;
  endtask

  task automatic wait_init8(input int exp_cycles);
    int n = 0;
    while (bus8.busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_val("init_len8", 64'(n), 64'(exp_cycles));
    check_val("valid_after_init8", 64'(bus8.ks_valid), 64'd1);
  endtask

  task automatic stream8(input int nwords);
    int got = 0;
    bus8.ks_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * nwords + 10 && got < nwords; cyc++) begin
      if (bus8.ks_valid) begin
        check_val("word8", 64'(bus8.ks_data), pop8());
        cnt8_exp += 64'd8;
        $display("word8 #%0d data=%h bits=%0d", got, bus8.ks_data, cnt8_exp);
        got++;
      end
      @(negedge clk);
    end
    check_val("words_seen8", 64'(got), 64'(nwords));
    bus8.ks_ready = 1'b0;
  endtask

  task automatic stall8(input int ncyc);
    bus8.ks_ready = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      check_val("stall_data8", 64'(bus8.ks_data), (exp8_q.size() != 0) ? exp8_q[0] : 'x);
      check_val("stall_valid8", 64'(bus8.ks_valid), 64'd1);
      @(negedge clk);
    end
  endtask

  task automatic check_idle8(input string tag);
    check_val({tag, "_busy"}, 64'(bus8.busy), 64'd0);
    check_val({tag, "_valid"}, 64'(bus8.ks_valid), 64'd0);
    check_val({tag, "_data"}, 64'(bus8.ks_data), 64'd0);
  endtask

  initial begin
    int n;
    int got;
    rst           = 1'b0;
    bus8.load     = 1'b0;
    bus8.key      = '0;
    bus8.iv       = '0;
    bus8.ks_ready = 1'b0;
    bus64.load    = 1'b0;
    bus64.key     = '0;
    bus64.iv      = '0;
    bus64.ks_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_idle8("reset");
    check_val("reset_valid64", 64'(bus64.ks_valid), 64'd0);
`ifdef TRIVIUM_CNT_EN
    check_val("reset_count8", bus8.ks_count, 64'd0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle8("idle");
    end

    // All-zero key/iv, 100 words with a 5-cycle stall after word 30.
    load8(80'h0, 80'h0);
    wait_init8(144);
    stream8(30);
    stall8(5);
    stream8(70);
`ifdef TRIVIUM_CNT_EN
    check_val("count_800", bus8.ks_count, 64'd800);
`endif

    // Rekey during warm-up, roughly 500 rounds in.
    load8(80'h3, 80'h5);
    repeat (62) @(negedge clk);
    check_val("busy_mid_init", 64'(bus8.busy), 64'd1);
    load8(80'h1, 80'hA5A5_5A5A_0F0F_F0F0_1234);
    wait_init8(144);
    stream8(16);

    // Rekey in RUN with a word pending and ready high in the same cycle.
    bus8.ks_ready = 1'b1;
    load8(80'h1, 80'h0);
    check_val("busy_after_run_load", 64'(bus8.busy), 64'd1);
    wait_init8(144);
    stream8(16);
`ifdef TRIVIUM_CNT_EN
    check_val("count_after_rekey", bus8.ks_count, 64'd128);
`endif

    // Asynchronous reset 60 cycles into warm-up.
    load8(80'hDEAD_BEEF_CAFE_F00D_4321, 80'h0BAD_F00D_1357_9BDF_2468);
    repeat (60) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle8("async_rst");
`ifdef TRIVIUM_CNT_EN
    check_val("async_rst_count", bus8.ks_count, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle8("post_rst");
    end

    // Wide instance: 18-cycle warm-up and 4096 bits against the same reference.
    gold_fill(80'h0123_4567_89AB_CDEF_1357, 80'hFEDC_BA98_7654_3210_0246);
    bus64.key  = 80'h0123_4567_89AB_CDEF_1357;
    bus64.iv   = 80'hFEDC_BA98_7654_3210_0246;
    bus64.load = 1'b1;
    @(negedge clk);
    bus64.load = 1'b0;
    n = 0;
    while (bus64.busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_val("init_len64", 64'(n), 64'd18);
    bus64.ks_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 64; cyc++) begin
      if (bus64.ks_valid) begin
        check_val("word64", bus64.ks_data, pop64());
        $display("word64 #%0d data=%h", got, bus64.ks_data);
        got++;
      end
      @(negedge clk);
    end
    check_val("words_seen64", 64'(got), 64'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
